ct_feeder: RTL and testbench

- Producer end of the ciphertext handshake (ct_addr/ct_rddata/ct_available/ct_read) that the arc4 decrypt cores consume.
- Streams a length-prefixed ciphertext from a source memory into a small circular prefetch buffer. Serves consumer reads with 1-cycle latency and frees buffer slots on ct_read pulses.
- Sits between ct_mem and one arc4 core. Uses the same en/rdy/done/halt control style as the rest of the cracker.

---
 rtl/cracker_pkg.sv | 14 +
 rtl/feeder_buf.sv | 34 +++
 rtl/ct_feeder.sv | 126 ++++++++++++
 tb/tb_ct_feeder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cracker_pkg.sv
// Shared types and constants for the ciphertext feeder and its neighbours.
package cracker_pkg;

    localparam int unsigned CNT_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LENW,
        STREAM,
        DRAIN
    } feeder_state_t;

endpackage

// File: rtl/feeder_buf.sv
// Circular prefetch buffer: one write port, one registered read port.
// A write to the slot being read in the same cycle is forwarded to rdata.
module feeder_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= 8'd0;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ct_feeder.sv
// Streams a length-prefixed ciphertext from source memory into a prefetch buffer
// and serves it to an arc4 core over the ct_addr/ct_rddata/ct_available/ct_read handshake.
module ct_feeder
    import cracker_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    input  logic       halt,
    output logic       done,
    output logic [7:0] msg_len,
    output logic [7:0] src_addr,
    input  logic [7:0] src_rddata,
    input  logic [7:0] ct_addr,
    output logic [7:0] ct_rddata,
    output logic       ct_available,
    input  logic       ct_read
);

    feeder_state_t    state;
    logic [CNT_W-1:0] iss_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt_next;
    logic [CNT_W-1:0] len_p1;
    logic [CNT_W-1:0] addr_ext;
    logic [7:0]       src_addr_q;
    logic             clear;
    logic             busy;
    logic             wr_en;
    logic             issue;
    logic             rd_acc;

    always_comb begin
        clear       = !rst_n || halt;
        busy        = (state != IDLE);
        rdy         = (state == IDLE);
        len_p1      = {1'b0, msg_len} + CNT_W'(1);
        addr_ext    = {1'b0, ct_addr};
        // At most one read is ever in flight, so a gap between issued and written means data is due.
        wr_en       = ((state == LENW) || (state == STREAM)) && (iss_cnt != wr_cnt);
        wr_cnt_next = wr_cnt + CNT_W'(wr_en);
        issue       = (state == LEN) ||
                      ((state == STREAM) && (iss_cnt < len_p1) &&
                       ((iss_cnt - rd_cnt) < CNT_W'(DEPTH)));
        rd_acc      = busy && ct_read && (rd_cnt < wr_cnt);
        // Hold the last issued address between issues so the bus stays quiet.
        src_addr    = issue ? iss_cnt[7:0] : src_addr_q;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            iss_cnt      <= '0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            msg_len      <= 8'd0;
            done         <= 1'b0;
            src_addr_q   <= 8'd0;
            ct_available <= 1'b0;
        end else begin
            if (issue) begin
                iss_cnt    <= iss_cnt + CNT_W'(1);
                src_addr_q <= iss_cnt[7:0];
            end
            if (wr_en) begin
                wr_cnt <= wr_cnt_next;
            end
            if (rd_acc) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            ct_available <= busy && (addr_ext >= rd_cnt) && (addr_ext < wr_cnt_next);

            unique case (state)
                IDLE: begin
                    if (en) begin
                        state   <= LEN;
                        iss_cnt <= '0;
                        wr_cnt  <= '0;
                        rd_cnt  <= '0;
                        done    <= 1'b0;
                    end
                end
                LEN: begin
                    state <= LENW;
                end
                LENW: begin
                    msg_len <= src_rddata;
                    state   <= (src_rddata == 8'd0) ? DRAIN : STREAM;
                end
                STREAM: begin
                    if (wr_cnt_next == len_p1) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_cnt == len_p1) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    feeder_buf #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_buf (
        .clk  (clk),
        .clr  (clear),
        .we   (wr_en),
        .waddr(wr_cnt[AW-1:0]),
        .wdata(src_rddata),
        .raddr(ct_addr[AW-1:0]),
        .rdata(ct_rddata)
    );

endmodule

// File: tb/tb_ct_feeder.sv
// Self-checking bench for ct_feeder: vector tables, timed corner sequences and a
// randomized consumer checked against byte-level rules of the handshake.
module tb_ct_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       halt = 1'b0;
    logic       ct_read = 1'b0;
    logic [7:0] ct_addr = 8'd0;
    logic [7:0] src_rddata;
    logic       rdy;
    logic       done;
    logic [7:0] msg_len;
    logic [7:0] src_addr;
    logic [7:0] ct_rddata;
    logic       ct_available;

    always #5 clk = ~clk;

    ct_feeder #(
        .DEPTH(DEPTH),
        .AW   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rdy         (rdy),
        .halt        (halt),
        .done        (done),
        .msg_len     (msg_len),
        .src_addr    (src_addr),
        .src_rddata  (src_rddata),
        .ct_addr     (ct_addr),
        .ct_rddata   (ct_rddata),
        .ct_available(ct_available),
        .ct_read     (ct_read)
    );

    // Source memory with one-cycle read latency, plus highest address ever requested.
    logic [7:0] src_mem [256];
    logic [7:0] max_addr;
    logic       max_clr = 1'b1;

    always @(posedge clk) begin
        src_rddata <= src_mem[src_addr];
        if (max_clr) max_addr <= 8'd0;
        else if (src_addr > max_addr) max_addr <= src_addr;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cur_len = 0;
    int rd_model = 0;
    bit auto_chk = 1'b0;

    typedef struct {
        logic [7:0] addr;
        logic       rd;
        logic       avail;
        logic [7:0] data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock; when enabled, checks the returned byte against the consumer-level rules.
    task automatic cycle();
        logic [7:0] a;
        a = ct_addr;
        @(posedge clk);
        #1;
        if (auto_chk) begin
            if (ct_available) chk("avail_data", 32'(ct_rddata), 32'(src_mem[a]));
            if (int'(a) < rd_model || int'(a) > cur_len || int'(a) >= rd_model + DEPTH)
                chk("no_spurious", 32'(ct_available), 32'd0);
        end
    endtask

    task automatic do_reset();
        auto_chk = 1'b0;
        rst_n = 1'b0; en = 1'b0; halt = 1'b0; ct_read = 1'b0; ct_addr = 8'd0;
        max_clr = 1'b1;
        repeat (2) cycle();
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_msg_len", 32'(msg_len), 32'd0);
        chk("rst_avail", 32'(ct_available), 32'd0);
        chk("rst_rddata", 32'(ct_rddata), 32'd0);
        chk("rst_src_addr", 32'(src_addr), 32'd0);
        rst_n = 1'b1;
        max_clr = 1'b0;
    endtask

    task automatic load(input int len);
        src_mem[0] = 8'(len);
        for (int i = 1; i < 256; i++) src_mem[i] = 8'($urandom_range(255, 1));
    endtask

    task automatic start();
        en = 1'b1;
        cycle();
        en = 1'b0;
        rd_model = 0;
        cur_len = int'(src_mem[0]);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 20) begin cycle(); t++; end
        chk(name, 32'(done), 32'd1);
    endtask

    // In-order consumer with random probing between bytes.
    task automatic consume(input int gap_max);
        for (int b = 0; b <= cur_len; b++) begin
            int t;
            int lo;
            int hi;
            lo = (b > 2) ? b - 2 : 0;
            hi = (b + DEPTH + 2 > 255) ? 255 : b + DEPTH + 2;
            repeat ($urandom_range(gap_max, 0)) begin
                ct_addr = 8'($urandom_range(hi, lo));
                cycle();
            end
            ct_addr = 8'(b);
            t = 0;
            cycle();
            while (!ct_available && t < 64) begin cycle(); t++; end
            chk("byte_wait", 32'(ct_available), 32'd1);
            ct_read = 1'b1;
            cycle();
            ct_read = 1'b0;
            rd_model++;
        end
        wait_done("consume_done");
    endtask

    initial begin
        vec_t t1[8];
        vec_t t3[6];
        logic       av[12];
        logic [7:0] dv[12];
        logic [7:0] stale5;
        int t;

        // Test 1: short message, table of reads including released/out-of-range probes.
        do_reset();
        load(3);
        src_mem[1] = 8'hA1; src_mem[2] = 8'hB2; src_mem[3] = 8'hC3;
        t1[0] = '{addr: 8'd0, rd: 1'b1, avail: 1'b1, data: 8'h03};
        t1[1] = '{addr: 8'd1, rd: 1'b0, avail: 1'b1, data: 8'hA1};
        t1[2] = '{addr: 8'd0, rd: 1'b0, avail: 1'b0, data: 8'h00};
        t1[3] = '{addr: 8'd1, rd: 1'b1, avail: 1'b1, data: 8'hA1};
        t1[4] = '{addr: 8'd2, rd: 1'b1, avail: 1'b1, data: 8'hB2};
        t1[5] = '{addr: 8'd4, rd: 1'b0, avail: 1'b0, data: 8'h00};
        t1[6] = '{addr: 8'd3, rd: 1'b0, avail: 1'b1, data: 8'hC3};
        t1[7] = '{addr: 8'd3, rd: 1'b1, avail: 1'b1, data: 8'hC3};
        start();
        ct_read = 1'b1;  // buffer empty: must be ignored
        cycle();
        ct_read = 1'b0;
        repeat (10) cycle();
        chk("t1_msg_len", 32'(msg_len), 32'd3);
        chk("t1_busy_rdy", 32'(rdy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ct_addr = t1[i].addr;
            ct_read = t1[i].rd;
            cycle();
            ct_read = 1'b0;
            chk($sformatf("t1_avail[%0d]", i), 32'(ct_available), 32'(t1[i].avail));
            if (t1[i].avail) chk($sformatf("t1_data[%0d]", i), 32'(ct_rddata), 32'(t1[i].data));
            chk($sformatf("t1_no_early_done[%0d]", i), 32'(done), 32'd0);
        end
        wait_done("t1_done");
        chk("t1_rdy_after", 32'(rdy), 32'd1);

        // Test 2: zero-length message.
        do_reset();
        load(0);
        start();
        auto_chk = 1'b1;
        consume(0);
        auto_chk = 1'b0;
        chk("t2_max_src_addr", 32'(max_addr), 32'd0);
        chk("t2_msg_len", 32'(msg_len), 32'd0);

        // Test 3: consumer stalls, buffer fills, one release unblocks a single fetch.
        do_reset();
        load(40);
        start();
        repeat (40) cycle();
        chk("t3_stall_max_addr", 32'(max_addr), 32'd15);
        en = 1'b1;  // not rdy: ignored
        cycle();
        en = 1'b0;
        t3[0] = '{addr: 8'd0,  rd: 1'b0, avail: 1'b1, data: src_mem[0]};
        t3[1] = '{addr: 8'd5,  rd: 1'b0, avail: 1'b1, data: src_mem[5]};
        t3[2] = '{addr: 8'd15, rd: 1'b0, avail: 1'b1, data: src_mem[15]};
        t3[3] = '{addr: 8'd16, rd: 1'b0, avail: 1'b0, data: 8'h00};
        t3[4] = '{addr: 8'd17, rd: 1'b0, avail: 1'b0, data: 8'h00};
        t3[5] = '{addr: 8'd40, rd: 1'b0, avail: 1'b0, data: 8'h00};
        for (int i = 0; i < 6; i++) begin
            ct_addr = t3[i].addr;
            ct_read = t3[i].rd;
            cycle();
            chk($sformatf("t3_avail[%0d]", i), 32'(ct_available), 32'(t3[i].avail));
            if (t3[i].avail) chk($sformatf("t3_data[%0d]", i), 32'(ct_rddata), 32'(t3[i].data));
        end
        ct_addr = 8'd16;
        ct_read = 1'b1;
        cycle();
        ct_read = 1'b0;
        t = 0;
        while (!ct_available && t < 3) begin cycle(); t++; end
        chk("t3_unblock_avail", 32'(ct_available), 32'd1);
        chk("t3_unblock_data", 32'(ct_rddata), 32'(src_mem[16]));
        repeat (5) cycle();
        chk("t3_one_more_issue", 32'(max_addr), 32'd16);
        stale5 = src_mem[5];

        // Test 4: polling a byte as it lands, with stale slot content that must not leak.
        do_reset();
        load(20);
        src_mem[5] = ~stale5;
        ct_addr = 8'd5;
        start();
        for (int k = 1; k <= 9; k++) begin
            cycle();
            av[k] = ct_available;
            dv[k] = ct_rddata;
        end
        chk("t4_addr5_before", 32'(av[7]), 32'd0);
        chk("t4_addr5_landing", 32'(av[8]), 32'd1);
        chk("t4_addr5_fwd_data", 32'(dv[8]), 32'(src_mem[5]));
        do_reset();
        ct_addr = 8'd6;
        start();
        for (int k = 1; k <= 9; k++) begin
            cycle();
            av[k] = ct_available;
        end
        chk("t4_addr6_same_cycle", 32'(av[8]), 32'd0);
        chk("t4_addr6_next", 32'(av[9]), 32'd1);

        // Test 5: halt mid-stream (wr_cnt=7) and a clean restart.
        do_reset();
        load(20);
        ct_addr = 8'd3;
        start();
        repeat (9) cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        chk("t5_halt_rdy", 32'(rdy), 32'd1);
        chk("t5_halt_done", 32'(done), 32'd0);
        chk("t5_halt_avail", 32'(ct_available), 32'd0);
        chk("t5_halt_msg_len", 32'(msg_len), 32'd0);
        src_mem[3] = ~src_mem[3];
        start();
        auto_chk = 1'b1;
        ct_addr = 8'd0;
        t = 0;
        cycle();
        while (!ct_available && t < 10) begin cycle(); t++; end
        chk("t5_byte0", 32'(ct_rddata), 32'd20);
        consume(2);
        auto_chk = 1'b0;

        // Test 6: maximum length, random payload and random consumer gaps.
        do_reset();
        load(255);
        for (int i = 1; i < 256; i++) src_mem[i] = 8'($urandom_range(255, 0));
        start();
        auto_chk = 1'b1;
        consume(3);
        auto_chk = 1'b0;
        chk("t6_msg_len", 32'(msg_len), 32'd255);
        chk("t6_max_src_addr", 32'(max_addr), 32'd255);
        ct_read = 1'b1;
        cycle();
        ct_read = 1'b0;
        cycle();
        chk("t6_done_hold", 32'(done), 32'd1);
        chk("t6_rdy_hold", 32'(rdy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
